// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory burst master.
package dmem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 1000;
  // Index width needed to address MEM_DEPTH words inside the memory array.
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_burst_master_if.sv
// Command, write-stream, read-stream and memory-port signals of one burst master.
interface dmem_burst_master_if;
  import dmem_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Burst master side.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done, err, mem_addr, mem_wdata, mem_we
  );

  // Command issuer / stream partner / memory side.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done, err, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/data_memory_multi_port.sv
// Shared 4-port data memory: combinational read, write on the clock edge.
// When several ports write the same word in one cycle the highest port wins.
module data_memory_multi_port
  import dmem_pkg::*;
(
  input  logic                         clk,
  input  logic [3:0]                   we,
  input  logic [3:0][ADDR_W-1:0]       addr,
  input  logic [3:0][DATA_W-1:0]       wdata,
  output logic [3:0][DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Commit writes in port order so a later port overrides an earlier one.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (we[p] && (addr[p] < ADDR_W'(MEM_DEPTH))) begin
        mem[addr[p][MEM_AW-1:0]] <= wdata[p];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign rdata[gi] = (addr[gi] < ADDR_W'(MEM_DEPTH)) ? mem[addr[gi][MEM_AW-1:0]] : '0;
    end
  endgenerate

endmodule

// File: rtl/dmem_rd_stage.sv
// One-entry read output register with valid/ready handshake.
// A new word may be loaded whenever the register is empty or is being drained.
module dmem_rd_stage
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              load,
  output logic              empty_or_draining
);

  logic              rd_valid_reg;
  logic [DATA_W-1:0] rd_data_reg;

  assign empty_or_draining = !rd_valid_reg || rd_ready;
  assign load              = load_req && empty_or_draining;
  assign rd_valid          = rd_valid_reg;
  assign rd_data           = rd_data_reg;

  // Load a fresh word, or clear valid once the held word is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else if (load) begin
      rd_data_reg  <= mem_rdata;
      rd_valid_reg <= 1'b1;
    end else if (rd_valid_reg && rd_ready) begin
      rd_valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_burst_master.sv
// Burst initiator for one port of the shared data memory. Accepts a
// base/length/direction command, then streams words to or from the memory.
module dmem_burst_master
  import dmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_burst_master_if.master  bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [ADDR_W-1:0] remaining_reg, remaining_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic [ADDR_W:0]   end_addr;
  logic              cmd_ok;
  logic              rd_load_req;
  logic              rd_load;
  logic              rd_empty_or_draining;

  // One extra bit so a burst ending past the top of the address space is still caught.
  assign end_addr = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign cmd_ok   = (bus.cmd_len != '0) && (end_addr <= (ADDR_W+1)'(MEM_DEPTH));

  assign rd_load_req = (state_reg == READ) && (remaining_reg != '0);

  dmem_rd_stage u_rd_stage (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_req          (rd_load_req),
    .mem_rdata         (bus.mem_rdata),
    .rd_ready          (bus.rd_ready),
    .rd_valid          (bus.rd_valid),
    .rd_data           (bus.rd_data),
    .load              (rd_load),
    .empty_or_draining (rd_empty_or_draining)
  );

  assign bus.done = done_reg;
  assign bus.err  = err_reg;

  // State, address/length counters and the done/err pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Next-state logic and memory-port / handshake outputs.
  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.wr_ready   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_we     = 1'b0;

    case (state_reg)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          if (cmd_ok) begin
            cur_addr_next  = bus.cmd_addr;
            remaining_next = bus.cmd_len;
            state_next     = bus.cmd_write ? WRITE : READ;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      WRITE: begin
        // The memory commits on the same edge that completes the handshake.
        bus.mem_addr  = cur_addr_reg;
        bus.mem_wdata = bus.wr_data;
        bus.wr_ready  = 1'b1;
        bus.mem_we    = bus.wr_valid;
        if (bus.wr_valid) begin
          cur_addr_next  = cur_addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - ADDR_W'(1);
          if (remaining_reg == ADDR_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      READ: begin
        bus.mem_addr = cur_addr_reg;
        if (rd_load) begin
          cur_addr_next  = cur_addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - ADDR_W'(1);
        end
        // Finish only once every word has left the output register.
        if ((remaining_reg == '0) && rd_empty_or_draining) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
